// File: rtl/fetch_pkg.sv
// Purpose : shared constants and types for the instruction-fetch stage.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), used for every IF/ID bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // REQ  : may issue a request (when the skid is empty)
    // WAIT : one live request outstanding, its response will be captured
    // DROP : one stale request outstanding (redirected away), its response is discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/preg_fetch.sv
// Purpose : IF/ID pipeline register with hold (stall) and bubble (flush).
// Latency : 1 cycle from i_load to outputs.
// Backpr. : i_stall holds contents; i_flush overrides stall and loads a bubble.
//
// Ports
//   i_clk, i_arst           clock, synchronous active-low reset
//   i_stall, i_flush        hold / bubble controls
//   i_load                  a real instruction is presented this cycle
//   i_instr/i_pc/i_pc_plus4 instruction entry to load
//   o_instr/o_pc/o_pc_plus4 registered entry; o_valid=0 marks a bubble/idle slot
module preg_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_load,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_valid
);

    localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP_INSTR);

    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pc_plus4_q, pc_plus4_d;
    logic                   valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (i_flush) begin
            instr_d    = NOP_W;
            pc_d       = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                instr_d    = i_instr;
                pc_d       = i_pc;
                pc_plus4_d = i_pc_plus4;
                valid_d    = 1'b1;
            end else begin
                // Decode consumed the entry and nothing new arrived: only the
                // valid bit drops, the payload is left as-is to avoid toggling.
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            instr_q    <= NOP_W;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign o_instr    = instr_q;
    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_plus4_q;
    assign o_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose : instruction fetch; owns the PC, one outstanding imem request, redirects.
// Latency : 1 cycle from i_imem_rvalid to o_instruction (unstalled).
// Backpr. : stall parks one response in a skid entry; no new request while it is full.
//
// Ports
//   i_clk, i_arst                  clock, synchronous active-low reset
//   i_stall_fetch, i_flush_dec     hazard unit hold / bubble
//   i_redirect, i_pc_target        taken branch/jump from execute
//   o_imem_req, o_imem_addr        request (accepted on o_imem_req & i_imem_ready)
//   i_imem_ready                   memory accepts this cycle
//   i_imem_rvalid, i_imem_rdata    response
//   o_instruction, o_pc, o_pc_plus4, o_instr_valid   IF/ID register to decode
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_flush_dec,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ready,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_instr_valid
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic [ADDR_WIDTH-1:0]  skid_pc4_q, skid_pc4_d;

    logic                   imem_req;
    logic                   accept;
    logic                   capture;
    logic [ADDR_WIDTH-1:0]  pc_plus4;

    logic                   preg_flush;
    logic                   preg_load;
    logic [INSTR_WIDTH-1:0] preg_instr;
    logic [ADDR_WIDTH-1:0]  preg_pc;
    logic [ADDR_WIDTH-1:0]  preg_pc4;

    // Modulo 2^ADDR_WIDTH: the all-ones-minus-3 PC wraps to zero.
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        preg_load    = 1'b0;
        preg_instr   = i_imem_rdata;
        preg_pc      = pc_q;
        preg_pc4     = pc_plus4;

        // Gated by reset so no request escapes while reset is held.
        imem_req = i_arst && (state_q == ST_REQ) && !skid_vld_q;
        accept   = imem_req && i_imem_ready;
        // A live response that is not being redirected away.
        capture  = (state_q == ST_WAIT) && i_imem_rvalid && !i_redirect;

        unique case (state_q)
            ST_REQ: begin
                // A request accepted in the same cycle as a redirect is stale.
                if (accept) state_d = i_redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (i_imem_rvalid)   state_d = ST_REQ;
                else if (i_redirect) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (i_imem_rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        if (capture)    pc_d = pc_plus4;
        if (i_redirect) pc_d = i_pc_target;

        // Skid: drained first when decode can accept, filled only by a
        // capture that lands while IF/ID is held. Both can't happen in one
        // cycle since no request is issued while the skid is occupied.
        if (i_redirect) begin
            skid_vld_d = 1'b0;
        end else if (skid_vld_q && !i_stall_fetch) begin
            skid_vld_d = 1'b0;
            preg_load  = 1'b1;
            preg_instr = skid_instr_q;
            preg_pc    = skid_pc_q;
            preg_pc4   = skid_pc4_q;
        end else if (capture) begin
            if (i_stall_fetch) begin
                skid_vld_d   = 1'b1;
                skid_instr_d = i_imem_rdata;
                skid_pc_d    = pc_q;
                skid_pc4_d   = pc_plus4;
            end else begin
                preg_load = 1'b1;
            end
        end
    end

    // A redirect bubbles IF/ID regardless of stall; a flush alone kills
    // whatever would have entered IF/ID this cycle.
    assign preg_flush = i_flush_dec || i_redirect;

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    preg_fetch #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_preg (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_stall    (i_stall_fetch),
        .i_flush    (preg_flush),
        .i_load     (preg_load),
        .i_instr    (preg_instr),
        .i_pc       (preg_pc),
        .i_pc_plus4 (preg_pc4),
        .o_instr    (o_instruction),
        .o_pc       (o_pc),
        .o_pc_plus4 (o_pc_plus4),
        .o_valid    (o_instr_valid)
    );

    assign o_imem_req  = imem_req;
    assign o_imem_addr = pc_q;

endmodule
